// File: rtl/chess_pkg.sv
// Shared chess types and constants: square encoding, board layout, start position
// and the board_state FSM encoding.
package chess_pkg;

  localparam int unsigned SQ_W    = 3;
  localparam int unsigned COORD_W = 3;
  localparam int unsigned BOARD_N = 8;

  localparam int unsigned OCC   = 0;
  localparam int unsigned COLOR = 1;
  localparam int unsigned KING  = 2;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef logic [SQ_W-1:0]    square_t;
  typedef logic [COORD_W-1:0] coord_t;
  typedef square_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

  typedef struct packed {
    coord_t src_row;
    coord_t src_col;
    coord_t dst_row;
    coord_t dst_col;
  } move_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    COMMIT = 3'd2,
    REJECT = 3'd3,
    RESP   = 3'd4
  } board_state_e;

  // Black occupies rows 0-1, white rows 6-7; kings sit in column 4.
  function automatic board_t init_board();
    board_t b;
    b = '0;
    for (int c = 0; c < int'(BOARD_N); c++) begin
      b[0][c] = 3'b011;
      b[1][c] = 3'b011;
      b[6][c] = 3'b001;
      b[7][c] = 3'b001;
    end
    b[0][4] = 3'b111;
    b[7][4] = 3'b101;
    return b;
  endfunction

  localparam board_t INIT_BOARD = init_board();

endpackage

// File: rtl/board_state_if.sv
// Move request handshake plus board/status outputs of board_state.
interface board_state_if
  import chess_pkg::*;
();

  logic   reqValid;
  logic   reqReady;
  coord_t srcRow;
  coord_t srcCol;
  coord_t dstRow;
  coord_t dstCol;
  board_t boardPos;
  logic   turn;
  logic   done;
  logic   accepted;
  logic   captured;
  logic   gameOver;

  modport master (
    output reqValid, srcRow, srcCol, dstRow, dstCol,
    input  reqReady, boardPos, turn, done, accepted, captured, gameOver
  );

  modport slave (
    input  reqValid, srcRow, srcCol, dstRow, dstCol,
    output reqReady, boardPos, turn, done, accepted, captured, gameOver
  );

endinterface

// File: rtl/move_check.sv
// Square-ownership legality of a move; piece shape is validated upstream.
module move_check
  import chess_pkg::*;
(
  input  square_t src_i,
  input  square_t dst_i,
  input  logic    turn_i,
  input  logic    same_sq_i,
  output logic    legal_o
);

  logic src_ok_c;
  logic dst_ok_c;

  assign src_ok_c = src_i[OCC] && (src_i[COLOR] == turn_i);
  assign dst_ok_c = !dst_i[OCC] || (dst_i[COLOR] != turn_i);
  assign legal_o  = src_ok_c && dst_ok_c && !same_sq_i;

endmodule

// File: rtl/board_state.sv
// Board register and move committer. Optional KING_CAPTURE_DETECT_EN makes a
// committed king capture set a sticky gameOver that blocks further requests.
module board_state
  import chess_pkg::*;
(
  input logic          clk,
  input logic          reset,
  board_state_if.slave bus
);

  board_state_e state_q, state_d;
  board_t       board_q, board_d;
  move_t        req_q, req_d;
  logic         turn_q, turn_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;
  logic         accepted_q, accepted_d;
  logic         captured_q, captured_d;
  logic         game_over_q, game_over_d;
  logic         same_sq_c;
  logic         legal_c;
  square_t      src_sq_c;
  square_t      dst_sq_c;

  assign src_sq_c  = board_q[req_q.src_row][req_q.src_col];
  assign dst_sq_c  = board_q[req_q.dst_row][req_q.dst_col];
  assign same_sq_c = (req_q.src_row == req_q.dst_row) && (req_q.src_col == req_q.dst_col);

  move_check u_move_check (
    .src_i     (src_sq_c),
    .dst_i     (dst_sq_c),
    .turn_i    (turn_q),
    .same_sq_i (same_sq_c),
    .legal_o   (legal_c)
  );

`ifdef KING_CAPTURE_DETECT_EN
  // COMMIT is only reachable for legal moves, so a king on dst is a capture.
  assign game_over_d = game_over_q || ((state_q == COMMIT) && dst_sq_c[KING]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      game_over_q <= 1'b0;
    end else begin
      game_over_q <= game_over_d;
    end
  end
`else
  assign game_over_d = 1'b0;
  assign game_over_q = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    req_d      = req_q;
    turn_d     = turn_q;
    done_d     = 1'b0;
    accepted_d = 1'b0;
    captured_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.reqValid && ready_q) begin
          req_d.src_row = bus.srcRow;
          req_d.src_col = bus.srcCol;
          req_d.dst_row = bus.dstRow;
          req_d.dst_col = bus.dstCol;
          state_d       = CHECK;
        end
      end
      CHECK: begin
        state_d = legal_c ? COMMIT : REJECT;
      end
      COMMIT: begin
        board_d[req_q.dst_row][req_q.dst_col] = src_sq_c;
        board_d[req_q.src_row][req_q.src_col] = '0;
        turn_d     = ~turn_q;
        done_d     = 1'b1;
        accepted_d = 1'b1;
        captured_d = dst_sq_c[OCC];
        state_d    = RESP;
      end
      REJECT: begin
        done_d  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE) && !game_over_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      board_q    <= INIT_BOARD;
      req_q      <= '0;
      turn_q     <= WHITE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      accepted_q <= 1'b0;
      captured_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      req_q      <= req_d;
      turn_q     <= turn_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      accepted_q <= accepted_d;
      captured_q <= captured_d;
    end
  end

  assign bus.reqReady = ready_q;
  assign bus.boardPos = board_q;
  assign bus.turn     = turn_q;
  assign bus.done     = done_q;
  assign bus.accepted = accepted_q;
  assign bus.captured = captured_q;
  assign bus.gameOver = game_over_q;

endmodule

// File: tb/tb_board_state.sv
// Scoreboard bench for board_state: directed moves push expected responses,
// a negedge monitor pops and compares on every done pulse.
module tb_board_state;
  import chess_pkg::*;

  typedef struct {
    logic   acc;
    logic   cap;
    logic   go;
    logic   turn;
    board_t board;
    int     hs;
  } exp_t;

`ifdef KING_CAPTURE_DETECT_EN
  localparam logic KC = 1'b1;
`else
  localparam logic KC = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t me;
  board_t mb;
  logic   mt;

  board_state_if bif ();

  board_state dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bif.done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        me = q.pop_front();
        check("done_latency", cyc, me.hs + 2);
        check("accepted", bif.accepted, me.acc);
        check("captured", bif.captured, me.cap);
        check("gameover", bif.gameOver, me.go);
        check("turn", bif.turn, me.turn);
        check("board", bif.boardPos, me.board);
      end
    end
  end

  task automatic do_req(input int sr, input int sc, input int dr, input int dc,
                        input logic acc, input logic cap, input logic go, input bit push);
    int   t;
    exp_t e;
    @(negedge clk);
    t = 0;
    while (!bif.reqReady && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bif.reqReady) begin
      check("ready_timeout", 0, 1);
      return;
    end
    bif.srcRow   = 3'(sr);
    bif.srcCol   = 3'(sc);
    bif.dstRow   = 3'(dr);
    bif.dstCol   = 3'(dc);
    bif.reqValid = 1'b1;
    @(posedge clk);
    #1;
    bif.reqValid = 1'b0;
    bif.srcRow   = 3'd7;
    bif.srcCol   = 3'd7;
    bif.dstRow   = 3'd0;
    bif.dstCol   = 3'd0;
    if (!push) return;
    if (acc) begin
      mb[dr][dc] = mb[sr][sc];
      mb[sr][sc] = '0;
      mt = ~mt;
    end
    e.acc   = acc;
    e.cap   = cap;
    e.go    = go;
    e.turn  = mt;
    e.board = mb;
    e.hs    = cyc;
    q.push_back(e);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ready_busy", bif.reqReady, 0);
    end
    @(negedge clk);
    check("ready_after", bif.reqReady, !go);
  endtask

  task automatic reset_checks();
    check("rst_board", bif.boardPos, INIT_BOARD);
    check("rst_sq_0_4", bif.boardPos[0][4], 3'b111);
    check("rst_sq_7_4", bif.boardPos[7][4], 3'b101);
    check("rst_sq_3_3", bif.boardPos[3][3], 3'b000);
    check("rst_turn", bif.turn, 0);
    check("rst_ready", bif.reqReady, 1);
    check("rst_done", bif.done, 0);
    check("rst_accepted", bif.accepted, 0);
    check("rst_captured", bif.captured, 0);
    check("rst_gameover", bif.gameOver, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mb = INIT_BOARD;
    mt = WHITE;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    bif.reqValid = 1'b0;
    bif.srcRow   = '0;
    bif.srcCol   = '0;
    bif.dstRow   = '0;
    bif.dstCol   = '0;
    mb = INIT_BOARD;
    mt = WHITE;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    reset_checks();

    // Rejections from the start position: wrong turn, own dst, same square, empty src.
    do_req(1, 0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_req(7, 1, 6, 3, 1'b0, 1'b0, 1'b0, 1'b1);
    do_req(6, 0, 6, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_req(4, 0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_req(6, 4, 4, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    check("sq_6_4", bif.boardPos[6][4], 3'b000);
    check("sq_4_4", bif.boardPos[4][4], 3'b001);
    check("turn_black", bif.turn, 1);

    // Build up white pawn on (3,3) and black pawn on (2,4), then capture.
    do_req(1, 4, 2, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    do_req(6, 3, 4, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    do_req(1, 0, 2, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_req(4, 3, 3, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    do_req(1, 1, 2, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    do_req(3, 3, 2, 4, 1'b1, 1'b1, 1'b0, 1'b1);
    do_req(2, 0, 2, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    check("sq_2_4", bif.boardPos[2][4], 3'b001);
    check("sq_3_3", bif.boardPos[3][3], 3'b000);

    do_reset();
    reset_checks();

    // Reset one cycle after the handshake aborts the move.
    do_req(6, 0, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_board", bif.boardPos, INIT_BOARD);
    check("abort_turn", bif.turn, 0);
    check("abort_ready", bif.reqReady, 1);

    // King capture onto (0,4).
    do_req(6, 0, 0, 4, 1'b1, 1'b1, KC, 1'b1);
    drain();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ready_post_king", bif.reqReady, !KC);
    end
    check("gameover_sticky", bif.gameOver, KC);
    check("sq_0_4", bif.boardPos[0][4], 3'b001);

    do_reset();
    reset_checks();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
